mem_port_arbiter: RTL and testbench

- Shares the single main-memory block port between the instruction cache refill path and the data cache refill/write-back path.
- Sits between `icache`/`dcache` and main memory.
- Serialises block transfers through a grant state machine and registers returned read data.
- Generates per-requester busywait, which the fetch unit and data path already OR into the pipeline stall.

---
 rtl/mem_port_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the main-memory block port between icache refill and dcache refill/write-back
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break in IDLE (default: dcache wins ties).
module mem_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_readdata,
  output logic              i_busywait,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_writedata,
  output logic [DATA_W-1:0] d_readdata,
  output logic              d_busywait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_busywait
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SERVE_I = 3'd1;
  localparam logic [2:0] SERVE_D = 3'd2;
  localparam logic [2:0] REL_I   = 3'd3;
  localparam logic [2:0] REL_D   = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic       seen_busy;
  logic       i_req;
  logic       d_req;
  logic       serving;
  logic       done;
  logic       pick_d;

  assign i_req   = i_read;
  assign d_req   = d_read | d_write;
  assign serving = (state == SERVE_I) || (state == SERVE_D);
  // Memory may assert busywait a cycle late, so a transfer is only finished
  // once busy has been observed and has since dropped.
  assign done    = serving && !mem_busywait && seen_busy;

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = dcache was granted most recently; reset to 1 so icache wins the first tie.
  logic last_grant;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    pick_d = d_req & (~i_req | ~last_grant);
  end

  // Remember which requester was granted, updated on entry to a SERVE state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (state_nxt == SERVE_I && state != SERVE_I) begin
      last_grant <= 1'b0;
    end else if (state_nxt == SERVE_D && state != SERVE_D) begin
      last_grant <= 1'b1;
    end
  end
`else
  // Fixed priority: dcache first so the memory stage is freed before fetch.
  always_comb begin
    pick_d = d_req;
  end
`endif

  // Grant sequencing; REL always hands off to the other side before idling.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d) begin
          state_nxt = SERVE_D;
        end else if (i_req) begin
          state_nxt = SERVE_I;
        end
      end
      SERVE_I: if (done) state_nxt = REL_I;
      SERVE_D: if (done) state_nxt = REL_D;
      REL_I:   state_nxt = d_req ? SERVE_D : IDLE;
      REL_D:   state_nxt = i_req ? SERVE_I : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Track whether memory has gone busy during the current SERVE; cleared on every state change.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seen_busy <= 1'b0;
    end else if (state_nxt != state) begin
      seen_busy <= 1'b0;
    end else if (serving && mem_busywait) begin
      seen_busy <= 1'b1;
    end
  end

  // Capture returned blocks on completion; a write-back leaves d_readdata alone.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_readdata <= '0;
      d_readdata <= '0;
    end else if (done) begin
      if (state == SERVE_I) begin
        i_readdata <= mem_readdata;
      end
      if (state == SERVE_D && d_read) begin
        d_readdata <= mem_readdata;
      end
    end
  end

  // Memory port drive; everything is zero outside the SERVE states.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    if (state == SERVE_I) begin
      mem_read    = 1'b1;
      mem_address = i_address;
    end else if (state == SERVE_D) begin
      mem_read      = d_read;
      mem_write     = d_write;
      mem_address   = d_address;
      mem_writedata = d_writedata;
    end
  end

  // Stall each requester while it has a request, except during its own release cycle.
  always_comb begin
    i_busywait = i_req & (state != REL_I);
    d_busywait = d_req & (state != REL_D);
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam logic [DW-1:0] BAD = {4{32'hBADBAD00}};

  logic          clock = 1'b0;
  logic          reset;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_readdata;
  logic          i_busywait;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [DW-1:0] d_writedata;
  logic [DW-1:0] d_readdata;
  logic          d_busywait;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata;
  logic          mem_busywait;

  int n_assert = 0;
  int n_fail   = 0;

  // Memory model: busy for mem_n cycles of strobe (optionally starting one cycle late).
  int            mem_n       = 1;
  bit            mem_delayed = 1'b0;
  logic [DW-1:0] mem_data    = '0;
  int            mem_cnt     = 0;
  logic          strobe;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
    .d_readdata(d_readdata), .d_busywait(d_busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  always #5 clock = ~clock;

  assign strobe       = mem_read | mem_write;
  assign mem_busywait = strobe && (mem_delayed ? (mem_cnt >= 1 && mem_cnt <= mem_n) : (mem_cnt < mem_n));
  assign mem_readdata = (strobe && mem_cnt == (mem_delayed ? mem_n + 1 : mem_n)) ? mem_data : BAD;

  always @(posedge clock) begin
    if (!strobe) mem_cnt <= 0;
    else         mem_cnt <= mem_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Observe from just after a negedge until the requester's busywait falls (its REL cycle).
  task automatic serve(input bit is_d, input logic rd, input logic wr, input logic [AW-1:0] ea,
                       input logic [DW-1:0] ewd, output int busy_cnt, output int match_cnt);
    bit fin;
    fin = 1'b0;
    busy_cnt = 0;
    match_cnt = 0;
    #1;
    for (int c = 0; c < 40 && !fin; c++) begin
      if ((is_d ? d_busywait : i_busywait) === 1'b1) begin
        busy_cnt++;
        if (mem_read === rd && mem_write === wr && mem_address === ea && mem_writedata === ewd)
          match_cnt++;
        @(negedge clock);
        #1;
      end else begin
        fin = 1'b1;
      end
    end
    if (!fin) busy_cnt = 999;
  endtask

  int            busy_cnt;
  int            match_cnt;
  logic [AW-1:0] exp_addr [9];
  logic          exp_rd   [9];
  logic          exp_ib   [9];
  logic          exp_db   [9];
  logic [AW-1:0] g        [4];
  logic [AW-1:0] exp_g    [4];
  int            ng;
  int            gap;
  int            gap_bad;
  bit            prev;
  bit            cur;
  bit            fin;

  initial begin
    reset = 1'b1;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_writedata = '0;

    // Reset state
    repeat (2) @(negedge clock);
    #1;
    chk("rst_i_busywait", 128'(i_busywait), 128'(1'b0));
    chk("rst_d_busywait", 128'(d_busywait), 128'(1'b0));
    chk("rst_mem_read", 128'(mem_read), 128'(1'b0));
    chk("rst_mem_write", 128'(mem_write), 128'(1'b0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_i_readdata", i_readdata, 128'(0));
    chk("rst_d_readdata", d_readdata, 128'(0));
    @(negedge clock);
    reset = 1'b0;

    // Uncontended icache read, memory busy 5
    @(negedge clock);
    mem_n = 5;
    mem_data = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    i_address = 28'h0000010;
    i_read = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 28'h0000010, '0, busy_cnt, match_cnt);
    chk("i_rd_busy_cycles", 128'(busy_cnt), 128'(7));
    chk("i_rd_strobe_cycles", 128'(match_cnt), 128'(6));
    chk("i_rd_rel_mem_read", 128'(mem_read), 128'(1'b0));
    chk("i_rd_readdata", i_readdata, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    i_read = 1'b0;
    @(negedge clock);
    #1;
    chk("i_rd_idle_mem_read", 128'(mem_read), 128'(1'b0));
    chk("i_rd_idle_busy", 128'(i_busywait), 128'(1'b0));

    // dcache write-back, memory busy 3; request held through REL to show busywait low one cycle
    @(negedge clock);
    mem_n = 3;
    d_address = 28'h0000020;
    d_writedata = {4{32'h11111111}};
    d_write = 1'b1;
    serve(1'b1, 1'b0, 1'b1, 28'h0000020, {4{32'h11111111}}, busy_cnt, match_cnt);
    chk("d_wr_busy_cycles", 128'(busy_cnt), 128'(5));
    chk("d_wr_strobe_cycles", 128'(match_cnt), 128'(4));
    chk("d_wr_rel_mem_write", 128'(mem_write), 128'(1'b0));
    @(negedge clock);
    #1;
    chk("d_wr_busy_back_high", 128'(d_busywait), 128'(1'b1));
    d_write = 1'b0;
    d_writedata = '0;
    @(negedge clock);
    #1;
    chk("d_wr_idle_busy", 128'(d_busywait), 128'(1'b0));
    chk("d_wr_idle_mem_write", 128'(mem_write), 128'(1'b0));
    chk("d_wr_readdata_kept", d_readdata, 128'(0));

    // Simultaneous icache and dcache reads, memory busy 2
`ifdef ARB_ROUND_ROBIN_EN
    exp_addr = '{28'h0, 28'h40, 28'h40, 28'h40, 28'h0, 28'h30, 28'h30, 28'h30, 28'h0};
    exp_ib   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_db   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
    exp_addr = '{28'h0, 28'h30, 28'h30, 28'h30, 28'h0, 28'h40, 28'h40, 28'h40, 28'h0};
    exp_ib   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_db   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    exp_rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clock);
    mem_n = 2;
    mem_data = 128'h33333333_44444444_55555555_66666666;
    i_address = 28'h0000040;
    d_address = 28'h0000030;
    i_read = 1'b1;
    d_read = 1'b1;
    #1;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("contend_c%0d", c),
          128'({mem_read, i_busywait, d_busywait, mem_address}),
          128'({exp_rd[c], exp_ib[c], exp_db[c], exp_addr[c]}));
      if (i_read && !i_busywait) i_read = 1'b0;
      if (d_read && !d_busywait) d_read = 1'b0;
      @(negedge clock);
      #1;
    end
    chk("contend_i_readdata", i_readdata, 128'h33333333_44444444_55555555_66666666);
    chk("contend_d_readdata", d_readdata, 128'h33333333_44444444_55555555_66666666);
    chk("contend_both_released", 128'({i_read, d_read}), 128'(2'b00));

    // Both requesters held for four transfers
`ifdef ARB_ROUND_ROBIN_EN
    exp_g = '{28'h60, 28'h50, 28'h60, 28'h50};
`else
    exp_g = '{28'h50, 28'h60, 28'h50, 28'h60};
`endif
    @(negedge clock);
    mem_n = 1;
    i_address = 28'h0000060;
    d_address = 28'h0000050;
    i_read = 1'b1;
    d_read = 1'b1;
    #1;
    ng = 0; gap = 0; gap_bad = 0; prev = 1'b0; fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      cur = strobe;
      if (cur && !prev) begin
        if (ng > 0 && gap != 1) gap_bad++;
        if (ng < 4) g[ng] = mem_address;
        ng++;
      end
      gap = cur ? 0 : gap + 1;
      if (prev && !cur && ng == 4) begin
        fin = 1'b1;
        i_read = 1'b0;
        d_read = 1'b0;
      end
      prev = cur;
      @(negedge clock);
      #1;
    end
    chk("rr_grant_count", 128'(ng), 128'(4));
    chk("rr_rel_gaps", 128'(gap_bad), 128'(0));
    for (int k = 0; k < 4; k++)
      chk($sformatf("rr_grant_%0d", k), 128'(g[k]), 128'(exp_g[k]));
    chk("rr_idle_busy", 128'({i_busywait, d_busywait, strobe}), 128'(3'b000));

    // Reset pulsed two cycles into an icache read
    @(negedge clock);
    mem_n = 5;
    mem_data = 128'h55AA55AA_00000001_00000002_00000003;
    i_address = 28'h0000070;
    i_read = 1'b1;
    @(negedge clock);
    #1;
    chk("rst_mid_serving", 128'(mem_read), 128'(1'b1));
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_mem_read", 128'(mem_read), 128'(1'b0));
    chk("rst_mid_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mid_i_readdata", i_readdata, 128'(0));
    chk("rst_mid_d_readdata", d_readdata, 128'(0));
    @(negedge clock);
    reset = 1'b0;
    serve(1'b0, 1'b1, 1'b0, 28'h0000070, '0, busy_cnt, match_cnt);
    chk("rst_regrant_busy_cycles", 128'(busy_cnt), 128'(7));
    chk("rst_regrant_strobe_cycles", 128'(match_cnt), 128'(6));
    chk("rst_regrant_readdata", i_readdata, 128'h55AA55AA_00000001_00000002_00000003);
    i_read = 1'b0;

    // Memory raising busywait one cycle after the strobe
    @(negedge clock);
    mem_delayed = 1'b1;
    mem_n = 3;
    mem_data = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    i_address = 28'h0000080;
    i_read = 1'b1;
    serve(1'b0, 1'b1, 1'b0, 28'h0000080, '0, busy_cnt, match_cnt);
    chk("late_busy_busy_cycles", 128'(busy_cnt), 128'(6));
    chk("late_busy_strobe_cycles", 128'(match_cnt), 128'(5));
    chk("late_busy_readdata", i_readdata, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0);
    i_read = 1'b0;
    @(negedge clock);
    #1;
    chk("late_busy_idle", 128'({mem_read, i_busywait}), 128'(2'b00));
    mem_delayed = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
